// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: frame constants, field widths, error codes and
// the frame-parser state encoding, reusable by controller/peripheral blocks.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ST   = 2'd1;
  localparam logic [1:0] ERR_OP   = 2'd2;
  localparam logic [1:0] ERR_TA   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } mdio_state_e;

  // Only the two clause-22 opcodes describe a real transaction.
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdc_edge_detect.sv
// Registers MDC once and flags the CLK cycle in which MDC has just risen.
module mdc_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_mdc,
  output logic o_rise
);

  logic r_mdc;

  // Previous-cycle copy of MDC for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_mdc <= 1'b0;
    else         r_mdc <= i_mdc;
  end

  assign o_rise = i_mdc & ~r_mdc;

endmodule

// File: rtl/mdio_frame_monitor.sv
// Passive MDIO clause-22 frame monitor: watches MDC/MDIO, reports complete
// frames with their fields, protocol errors, and a running valid-frame count.
module mdio_frame_monitor
  import mdio_pkg::*;
#(
  parameter int MIN_PREAMBLE = 32,
  parameter int CNT_W        = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_mdc,
  input  logic                 i_mdio_oe,
  input  logic                 i_mdio_out,
  input  logic                 i_mdio_in,
  output logic                 o_frame_valid,
  output logic                 o_frame_wr,
  output logic [PHYAD_W-1:0]   o_frame_phyad,
  output logic [REGAD_W-1:0]   o_frame_regad,
  output logic [DATA_W-1:0]    o_frame_data,
  output logic                 o_frame_err,
  output logic [1:0]           o_err_code,
  output logic [CNT_W-1:0]     o_frame_cnt
);

  localparam int                PRE_W   = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MIN_PREAMBLE);

  logic               w_sample;
  logic               w_line;
  logic               w_ta_ok;

  mdio_state_e        r_state;
  logic [PRE_W-1:0]   r_pre_cnt;
  logic [3:0]         r_bit_cnt;
  logic               r_op_hi;
  logic               r_wr;
  logic               r_ta_bad;
  logic [PHYAD_W-1:0] r_phyad;
  logic [REGAD_W-1:0] r_regad;
  logic [DATA_W-1:0]  r_data;

  mdc_edge_detect u_mdc_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_mdc   (i_mdc),
    .o_rise  (w_sample)
  );

  // Whoever currently owns the wire determines the observed bit.
  assign w_line = i_mdio_oe ? i_mdio_out : i_mdio_in;

  // Write TA: controller drives 1,0. Read TA: peripheral owns both bits,
  // first value is don't-care (line is turning around), second must be 0.
  assign w_ta_ok = r_wr ? (i_mdio_oe && (w_line == (r_bit_cnt == 4'd0)))
                        : (!i_mdio_oe && ((r_bit_cnt == 4'd0) || !w_line));

  // Frame parser FSM with registered result and error outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pre_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_op_hi       <= 1'b0;
      r_wr          <= 1'b0;
      r_ta_bad      <= 1'b0;
      r_phyad       <= '0;
      r_regad       <= '0;
      r_data        <= '0;
      o_frame_valid <= 1'b0;
      o_frame_wr    <= 1'b0;
      o_frame_phyad <= '0;
      o_frame_regad <= '0;
      o_frame_data  <= '0;
      o_frame_err   <= 1'b0;
      o_err_code    <= ERR_NONE;
      o_frame_cnt   <= '0;
    end else begin
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      if (w_sample) begin
        unique case (r_state)
          S_IDLE: begin
            // Count is saturating, so reaching PRE_MAX means ">= MIN_PREAMBLE".
            // A short preamble ending in 0 is just line noise: restart quietly.
            if (w_line) begin
              if (r_pre_cnt != PRE_MAX) r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end else begin
              r_pre_cnt <= '0;
              if (r_pre_cnt == PRE_MAX) r_state <= S_ST;
            end
          end
          S_ST: begin
            if (w_line == ST[0]) begin
              r_state   <= S_OP;
              r_bit_cnt <= '0;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_ST;
              r_state     <= S_IDLE;
              r_pre_cnt   <= '0;
            end
          end
          S_OP: begin
            if (r_bit_cnt == 4'd0) begin
              r_op_hi   <= w_line;
              r_bit_cnt <= 4'd1;
            end else if (op_is_valid({r_op_hi, w_line})) begin
              r_wr      <= ({r_op_hi, w_line} == OP_WRITE);
              r_state   <= S_PHYAD;
              r_bit_cnt <= '0;
            end else begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_OP;
              r_state     <= S_IDLE;
              r_pre_cnt   <= '0;
            end
          end
          S_PHYAD: begin
            r_phyad <= {r_phyad[PHYAD_W-2:0], w_line};
            if (r_bit_cnt == 4'(PHYAD_W - 1)) begin
              r_state   <= S_REGAD;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_REGAD: begin
            r_regad <= {r_regad[REGAD_W-2:0], w_line};
            if (r_bit_cnt == 4'(REGAD_W - 1)) begin
              r_state   <= S_TA;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_TA: begin
            // Both TA bits are always taken; the verdict is given after the second.
            if (r_bit_cnt == 4'd0) begin
              r_ta_bad  <= !w_ta_ok;
              r_bit_cnt <= 4'd1;
            end else if (r_ta_bad || !w_ta_ok) begin
              o_frame_err <= 1'b1;
              o_err_code  <= ERR_TA;
              r_state     <= S_IDLE;
              r_pre_cnt   <= '0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_data <= {r_data[DATA_W-2:0], w_line};
            if (r_bit_cnt == 4'(DATA_W - 1)) begin
              o_frame_valid <= 1'b1;
              o_frame_wr    <= r_wr;
              o_frame_phyad <= r_phyad;
              o_frame_regad <= r_regad;
              o_frame_data  <= {r_data[DATA_W-2:0], w_line};
              o_frame_cnt   <= o_frame_cnt + CNT_W'(1);
              r_state       <= S_IDLE;
              r_pre_cnt     <= '0;
              r_bit_cnt     <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_frame_monitor.sv
// Directed bench for mdio_frame_monitor: table of whole frames with
// hand-computed results, plus reset-mid-frame and counter-wrap sequences.
module tb_mdio_frame_monitor;
  import mdio_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mdc = 1'b0;
  logic oe  = 1'b0;
  logic mo  = 1'b0;
  logic mi  = 1'b0;

  logic        o_valid, o_wr, o_err;
  logic [4:0]  o_phy, o_rg;
  logic [15:0] o_data;
  logic [1:0]  o_code;
  logic [7:0]  o_cnt;

  logic        d2_valid, d2_wr, d2_err;
  logic [4:0]  d2_phy, d2_rg;
  logic [15:0] d2_data;
  logic [1:0]  d2_code;
  logic [1:0]  d2_cnt;

  int n_chk = 0;
  int n_err = 0;
  int v_cnt = 0, e_cnt = 0, v2_cnt = 0, e2_cnt = 0;

  always #5 clk = ~clk;

  mdio_frame_monitor #(.MIN_PREAMBLE(32), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_mdc(mdc), .i_mdio_oe(oe),
    .i_mdio_out(mo), .i_mdio_in(mi),
    .o_frame_valid(o_valid), .o_frame_wr(o_wr), .o_frame_phyad(o_phy),
    .o_frame_regad(o_rg), .o_frame_data(o_data), .o_frame_err(o_err),
    .o_err_code(o_code), .o_frame_cnt(o_cnt)
  );

  mdio_frame_monitor #(.MIN_PREAMBLE(32), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_mdc(mdc), .i_mdio_oe(oe),
    .i_mdio_out(mo), .i_mdio_in(mi),
    .o_frame_valid(d2_valid), .o_frame_wr(d2_wr), .o_frame_phyad(d2_phy),
    .o_frame_regad(d2_rg), .o_frame_data(d2_data), .o_frame_err(d2_err),
    .o_err_code(d2_code), .o_frame_cnt(d2_cnt)
  );

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (o_valid)  v_cnt++;
    if (o_err)    e_cnt++;
    if (d2_valid) v2_cnt++;
    if (d2_err)   e2_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One MDIO bit: data set up with MDC low, then MDC high for two cycles.
  task automatic send_bit(input logic b_oe, input logic b_out, input logic b_in);
    @(negedge clk);
    oe = b_oe; mo = b_out; mi = b_in; mdc = 1'b0;
    repeat (2) @(negedge clk);
    mdc = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Preamble then up to nbits of ST/OP/PHYAD/REGAD/TA/DATA (32 = full frame).
  task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] rg,
                            input logic [1:0] ta, input logic ta_oe, input logic rd,
                            input logic [15:0] data, input int nbits);
    logic [13:0] hdr;
    logic        b;
    hdr = {st, op, phy, rg};
    for (int k = 0; k < pre; k++) send_bit(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < nbits; k++) begin
      if (k < 14) begin
        send_bit(1'b1, hdr[13-k], 1'b0);
      end else if (k < 16) begin
        b = ta[15-k];
        if (ta_oe) send_bit(1'b1, b, 1'b0);
        else       send_bit(1'b0, 1'b1, b);
      end else begin
        b = data[31-k];
        if (rd) send_bit(1'b0, 1'b1, b);
        else    send_bit(1'b1, b, 1'b0);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  st, op;
    logic [4:0]  phy, rg;
    logic [1:0]  ta;
    logic        ta_oe, rd;
    logic [15:0] data;
    int          x_v, x_e;
    logic [1:0]  x_code;
    logic        x_wr;
    logic [4:0]  x_phy, x_rg;
    logic [15:0] x_data;
    logic [7:0]  x_cnt;
  } vec_t;

  vec_t tv[12];

  initial begin
    int v0, e0, v20, e20;
    // pre  st     op     phy    rg     ta   ta_oe rd  data       v e code  wr  phy   rg     data      cnt
    tv[0]  = '{32, 2'b01, 2'b01, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 1, 0, 2'd0, 1'b1, 5'h03, 5'h0A, 16'hBEEF, 8'd1};
    tv[1]  = '{32, 2'b01, 2'b10, 5'h1F, 5'h02, 2'b10, 1'b0, 1'b1, 16'h1234, 1, 0, 2'd0, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[2]  = '{31, 2'b01, 2'b01, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 0, 0, 2'd0, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[3]  = '{32, 2'b01, 2'b11, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 0, 1, 2'd2, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[4]  = '{32, 2'b01, 2'b01, 5'h03, 5'h0A, 2'b11, 1'b1, 1'b0, 16'hBEEF, 0, 1, 2'd3, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[5]  = '{32, 2'b01, 2'b00, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 0, 1, 2'd2, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[6]  = '{32, 2'b01, 2'b10, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b1, 16'hBEEF, 0, 1, 2'd3, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[7]  = '{32, 2'b01, 2'b10, 5'h03, 5'h0A, 2'b01, 1'b0, 1'b1, 16'hBEEF, 0, 1, 2'd3, 1'b0, 5'h1F, 5'h02, 16'h1234, 8'd2};
    tv[8]  = '{32, 2'b01, 2'b10, 5'h05, 5'h11, 2'b00, 1'b0, 1'b1, 16'hA5C3, 1, 0, 2'd3, 1'b0, 5'h05, 5'h11, 16'hA5C3, 8'd3};
    tv[9]  = '{32, 2'b00, 2'b01, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 0, 1, 2'd1, 1'b0, 5'h05, 5'h11, 16'hA5C3, 8'd3};
    tv[10] = '{32, 2'b01, 2'b01, 5'h03, 5'h0A, 2'b00, 1'b1, 1'b0, 16'hBEEF, 0, 1, 2'd3, 1'b0, 5'h05, 5'h11, 16'hA5C3, 8'd3};
    tv[11] = '{40, 2'b01, 2'b01, 5'h00, 5'h1F, 2'b10, 1'b1, 1'b0, 16'h0001, 1, 0, 2'd3, 1'b1, 5'h00, 5'h1F, 16'h0001, 8'd4};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(o_valid), 32'd0);
    chk("rst err",   32'(o_err),   32'd0);
    chk("rst code",  32'(o_code),  32'd0);
    chk("rst cnt",   32'(o_cnt),   32'd0);
    chk("rst data",  32'(o_data),  32'd0);
    chk("rst phy",   32'({o_wr, o_phy, o_rg}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of whole frames
    for (int i = 0; i < 12; i++) begin
      v0 = v_cnt; e0 = e_cnt;
      send_frame(tv[i].pre, tv[i].st, tv[i].op, tv[i].phy, tv[i].rg, tv[i].ta,
                 tv[i].ta_oe, tv[i].rd, tv[i].data, 32);
      chk($sformatf("v%0d valid", i), 32'(v_cnt - v0), 32'(tv[i].x_v));
      chk($sformatf("v%0d err", i),   32'(e_cnt - e0), 32'(tv[i].x_e));
      chk($sformatf("v%0d code", i),  32'(o_code), 32'(tv[i].x_code));
      chk($sformatf("v%0d wr", i),    32'(o_wr),   32'(tv[i].x_wr));
      chk($sformatf("v%0d phy", i),   32'(o_phy),  32'(tv[i].x_phy));
      chk($sformatf("v%0d reg", i),   32'(o_rg),   32'(tv[i].x_rg));
      chk($sformatf("v%0d data", i),  32'(o_data), 32'(tv[i].x_data));
      chk($sformatf("v%0d cnt", i),   32'(o_cnt),  32'(tv[i].x_cnt));
    end

    // Reset after 8 data bits of a write: partial frame vanishes silently
    v0 = v_cnt; e0 = e_cnt;
    send_frame(32, ST, OP_WRITE, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 24);
    rst = 1'b1; mdc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst valid", 32'(v_cnt - v0), 32'd0);
    chk("midrst err",   32'(e_cnt - e0), 32'd0);
    chk("midrst cnt",   32'(o_cnt),  32'd0);
    chk("midrst code",  32'(o_code), 32'd0);
    chk("midrst data",  32'(o_data), 32'd0);
    chk("midrst fields", 32'({o_wr, o_phy, o_rg}), 32'd0);
    v0 = v_cnt;
    send_frame(32, ST, OP_WRITE, 5'h03, 5'h0A, 2'b10, 1'b1, 1'b0, 16'hBEEF, 32);
    chk("postrst valid", 32'(v_cnt - v0), 32'd1);
    chk("postrst wr",    32'(o_wr),   32'd1);
    chk("postrst phy",   32'(o_phy),  32'h03);
    chk("postrst reg",   32'(o_rg),   32'h0A);
    chk("postrst data",  32'(o_data), 32'hBEEF);
    chk("postrst cnt",   32'(o_cnt),  32'd1);

    // 2-bit counter wraps: 1,2,3,0,1
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      v20 = v2_cnt; e20 = e2_cnt;
      send_frame(32, ST, OP_WRITE, 5'(i), 5'(i + 8), 2'b10, 1'b1, 1'b0, 16'(16'h1000 + i), 32);
      chk($sformatf("wrap%0d cnt", i),   32'(d2_cnt),  32'((i + 1) % 4));
      chk($sformatf("wrap%0d valid", i), 32'(v2_cnt - v20), 32'd1);
      chk($sformatf("wrap%0d err", i),   32'(e2_cnt - e20), 32'd0);
      chk($sformatf("wrap%0d fields", i), 32'({d2_wr, d2_code, d2_phy, d2_rg}),
          32'({1'b1, 2'b00, 5'(i), 5'(i + 8)}));
      chk($sformatf("wrap%0d data", i),  32'(d2_data), 32'(16'h1000 + i));
      chk($sformatf("wrap%0d cnt8", i),  32'(o_cnt),   32'(i + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
